// File: rtl/vector_normalizer.sv
// vector_normalizer: fixed-latency (67 cycle) Q16.16 2-D magnitude and unit-vector unit.
// Define NORMALIZER_ROUND_EN for round-to-nearest sqrt/quotients; default build truncates.
module vector_normalizer #(
    parameter logic [31:0] ZERO_THRESH = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] vx,
    input  logic [31:0] vy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mag,
    output logic [31:0] xn,
    output logic [31:0] yn,
    output logic        zero
);

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        SQRT,
        DIV_X,
        DIV_Y,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] vx_q, vx_d;
    logic [31:0] vy_q, vy_d;
    logic [63:0] rad_q, rad_d;
    logic [33:0] rem_q, rem_d;
    logic [31:0] root_q, root_d;
    logic [48:0] drem_q, drem_d;
    logic [48:0] ddiv_q, ddiv_d;
    logic [16:0] quo_q, quo_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] xn_q, xn_d;
    logic [31:0] yn_q, yn_d;
    logic        zero_q, zero_d;

    logic [31:0] absX, absY;
    logic [63:0] sumSq;
    logic [35:0] remSh, trial;
    logic        sqGe;
    logic [33:0] remNext;
    logic [31:0] rootNext, rootFinal;
    logic        divGe;
    logic [48:0] dremNext;
    logic [16:0] quoNext;
    logic [17:0] qRound;
    logic [16:0] qClamp;
    logic        compNeg, isZero;
    logic [31:0] compResult;

    assign absX  = vx_q[31] ? (~vx_q + 32'd1) : vx_q;
    assign absY  = vy_q[31] ? (~vy_q + 32'd1) : vy_q;
    assign sumSq = ({32'd0, absX} * {32'd0, absX}) + ({32'd0, absY} * {32'd0, absY});

    // One restoring square-root digit per cycle, consuming two radicand bits MSB first.
    assign remSh    = {rem_q, rad_q[63:62]};
    assign trial    = {2'b00, root_q, 2'b01};
    assign sqGe     = (remSh >= trial);
    assign remNext  = sqGe ? 34'(remSh - trial) : remSh[33:0];
    assign rootNext = {root_q[30:0], sqGe};

    // The divisor starts aligned to quotient bit 16 and walks right one bit per cycle.
    assign divGe    = (drem_q >= ddiv_q);
    assign dremNext = divGe ? (drem_q - ddiv_q) : drem_q;
    assign quoNext  = {quo_q[15:0], divGe};

`ifdef NORMALIZER_ROUND_EN
    assign rootFinal = (remNext > {2'b00, rootNext}) ? (rootNext + 32'd1) : rootNext;
    assign qRound    = {1'b0, quoNext} + {17'd0, ({dremNext, 1'b0} >= {18'd0, root_q})};
`else
    assign rootFinal = rootNext;
    assign qRound    = {1'b0, quoNext};
`endif

    assign qClamp     = (qRound > 18'h1_0000) ? 17'h1_0000 : qRound[16:0];
    assign compNeg    = (state_q == DIV_Y) ? vy_q[31] : vx_q[31];
    assign isZero     = (root_q <= ZERO_THRESH);
    assign compResult = isZero ? 32'd0 : (compNeg ? -{15'd0, qClamp} : {15'd0, qClamp});

    // Sequencing: each stage runs a fixed cycle count so latency never depends on data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid) state_d = SQUARE;
            end
            SQUARE: begin
                cnt_d   = '0;
                state_d = SQRT;
            end
            SQRT: begin
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = DIV_X;
                end
            end
            DIV_X: begin
                if (cnt_q == 6'd16) begin
                    cnt_d   = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                if (cnt_q == 6'd16) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        vx_d   = vx_q;
        vy_d   = vy_q;
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        drem_d = drem_q;
        ddiv_d = ddiv_q;
        quo_d  = quo_q;
        mag_d  = mag_q;
        xn_d   = xn_q;
        yn_d   = yn_q;
        zero_d = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vx_d = vx;
                    vy_d = vy;
                end
            end
            SQUARE: begin
                rad_d  = sumSq;
                rem_d  = '0;
                root_d = '0;
            end
            SQRT: begin
                rad_d  = {rad_q[61:0], 2'b00};
                rem_d  = remNext;
                root_d = rootNext;
                if (cnt_q == 6'd31) begin
                    root_d = rootFinal;
                    drem_d = {1'b0, absX, 16'h0000};
                    ddiv_d = {1'b0, rootFinal, 16'h0000};
                    quo_d  = '0;
                end
            end
            DIV_X, DIV_Y: begin
                drem_d = dremNext;
                ddiv_d = {1'b0, ddiv_q[48:1]};
                quo_d  = quoNext;
                if (cnt_q == 6'd16) begin
                    if (state_q == DIV_X) begin
                        xn_d   = compResult;
                        drem_d = {1'b0, absY, 16'h0000};
                        ddiv_d = {1'b0, root_q, 16'h0000};
                        quo_d  = '0;
                    end else begin
                        yn_d   = compResult;
                        mag_d  = root_q[31] ? 32'h7FFF_FFFF : root_q;
                        zero_d = isZero;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            drem_q  <= '0;
            ddiv_q  <= '0;
            quo_q   <= '0;
            mag_q   <= '0;
            xn_q    <= '0;
            yn_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            drem_q  <= drem_d;
            ddiv_q  <= ddiv_d;
            quo_q   <= quo_d;
            mag_q   <= mag_d;
            xn_q    <= xn_d;
            yn_q    <= yn_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mag       = mag_q;
    assign xn        = xn_q;
    assign yn        = yn_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_vector_normalizer.sv
// tb_vector_normalizer: directed vectors checked against an arithmetic reference model.
// Honours NORMALIZER_ROUND_EN the same way the design does.
module tb_vector_normalizer;

    localparam logic [31:0] ZT = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] vx = '0;
    logic [31:0] vy = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] mag, xn, yn;
    logic        zero;

    int checks = 0;
    int failures = 0;

    logic        expPending = 1'b0;
    logic [31:0] expMag = '0, expXn = '0, expYn = '0;
    logic        expZero = 1'b0;

    vector_normalizer #(.ZERO_THRESH(ZT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vx(vx), .vy(vy), .out_valid(out_valid), .out_ready(out_ready),
        .mag(mag), .xn(xn), .yn(yn), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    function automatic logic [31:0] modelComp(input longint unsigned a, input logic neg,
                                              input longint unsigned r, input logic z);
        longint unsigned q, rem;
        logic [31:0] v;
        if (z) return 32'd0;
        q   = (a << 16) / r;
        rem = (a << 16) % r;
`ifdef NORMALIZER_ROUND_EN
        if (2 * rem >= r) q = q + 1;
`endif
        if (q > 65536) q = 65536;
        v = q[31:0];
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Exact integer sqrt by bitwise trial squares, then plain division for each component.
    task automatic modelNormalize(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] m, output logic [31:0] xo,
                                  output logic [31:0] yo, output logic z);
        longint unsigned ax, ay, s, r, t;
        ax = {32'd0, (x[31] ? (~x + 32'd1) : x)};
        ay = {32'd0, (y[31] ? (~y + 32'd1) : y)};
        s  = ax * ax + ay * ay;
        r  = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= s) r = t;
        end
`ifdef NORMALIZER_ROUND_EN
        if (s - r * r > r) r = r + 1;
`endif
        z  = (r <= {32'd0, ZT});
        m  = (r > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : r[31:0];
        xo = modelComp(ax, x[31], r, z);
        yo = modelComp(ay, y[31], r, z);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expPending) begin
                checkOutput("mag", mag, expMag);
                checkOutput("xn", xn, expXn);
                checkOutput("yn", yn, expYn);
                checkOutput("zero", {31'd0, zero}, {31'd0, expZero});
            end else begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_out_valid: actual=1 required=0");
            end
        end
    end

    task automatic acceptVector(input logic [31:0] x, input logic [31:0] y);
        int waitCnt;
        @(negedge clk);
        vx = x;
        vy = y;
        in_valid = 1'b1;
        waitCnt = 0;
        while (!in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vx = ~x;
        vy = x ^ 32'h5A5A_1234;
    endtask

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input int hold,
                                 input logic lit, input logic [31:0] litMag, input logic [31:0] litXn,
                                 input logic [31:0] litYn, input logic litZero);
        logic [31:0] m, xo, yo;
        logic z;
        int edges;
        modelNormalize(x, y, m, xo, yo, z);
        if (lit) begin
            checkOutput("model_mag", m, litMag);
            checkOutput("model_xn", xo, litXn);
            checkOutput("model_yn", yo, litYn);
            checkOutput("model_zero", {31'd0, z}, {31'd0, litZero});
        end
        expMag = m;
        expXn = xo;
        expYn = yo;
        expZero = z;
        expPending = 1'b1;
        out_ready = (hold == 0);
        acceptVector(x, y);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", edges, 32'd67);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expPending = 1'b0;
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic applyAbort(input logic [31:0] x, input logic [31:0] y);
        int seen;
        acceptVector(x, y);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_mag", mag, 32'd0);
        checkOutput("abort_xn", xn, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", seen, 32'd0);
        checkOutput("abort_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_mag", mag, 32'd0);
        checkOutput("reset_xn", xn, 32'd0);
        checkOutput("reset_yn", yn, 32'd0);
        checkOutput("reset_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;

`ifdef NORMALIZER_ROUND_EN
        applyStimulus(32'h0003_0000, 32'h0004_0000, 0, 1'b1, 32'h0005_0000, 32'h0000_999A, 32'h0000_CCCD, 1'b0);
        applyStimulus(32'hFFFD_0000, 32'h0004_0000, 0, 1'b1, 32'h0005_0000, 32'hFFFF_6666, 32'h0000_CCCD, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_4AFB, 32'hFFFF_4AFB, 1'b0);
        applyStimulus(32'h0005_0000, 32'hFFF4_0000, 10, 1'b1, 32'h000D_0000, 32'h0000_6276, 32'hFFFF_13B1, 1'b0);
`else
        applyStimulus(32'h0003_0000, 32'h0004_0000, 0, 1'b1, 32'h0005_0000, 32'h0000_9999, 32'h0000_CCCC, 1'b0);
        applyStimulus(32'hFFFD_0000, 32'h0004_0000, 0, 1'b1, 32'h0005_0000, 32'hFFFF_6667, 32'h0000_CCCC, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_4AFC, 32'hFFFF_4AFC, 1'b0);
        applyStimulus(32'h0005_0000, 32'hFFF4_0000, 10, 1'b1, 32'h000D_0000, 32'h0000_6276, 32'hFFFF_13B2, 1'b0);
`endif
        applyStimulus(32'h0000_0000, 32'h0014_0000, 0, 1'b1, 32'h0014_0000, 32'h0000_0000, 32'h0001_0000, 1'b0);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        applyStimulus(32'hFFFF_0000, 32'h0000_0000, 0, 1'b1, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(32'h0000_0001, 32'h0000_0000, 0, 1'b0, '0, '0, '0, 1'b0);
        applyStimulus(32'h1234_5678, 32'hFEDC_BA98, 3, 1'b0, '0, '0, '0, 1'b0);

        applyAbort(32'h0007_0000, 32'h0001_0000);
        applyStimulus(32'h0007_0000, 32'h0001_0000, 0, 1'b0, '0, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_normalizer.md
VECTOR_NORMALIZER -- requirements
Module: vector_normalizer

Interface
REQ-001 SHALL have parameter ZERO_THRESH, default 0, unsigned Q16.16 magnitude at or below which the vector is treated as zero.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  vx/vy valid.
REQ-005 SHALL have port in_ready  output  1  block idle, can accept a vector.
REQ-006 SHALL have port vx  input  32  signed Q16.16 x component.
REQ-007 SHALL have port vy  input  32  signed Q16.16 y component.
REQ-008 SHALL have port out_valid  output  1  mag/xn/yn/zero valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port mag  output  32  signed Q16.16 magnitude, always >= 0.
REQ-011 SHALL have port xn  output  32  signed Q16.16 unit x component.
REQ-012 SHALL have port yn  output  32  signed Q16.16 unit y component.
REQ-013 SHALL have port zero  output  1  vector treated as zero.

Function
REQ-014 SHALL use FSM states IDLE, SQUARE, SQRT, DIV_X, DIV_Y, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL capture vx, vy and go IDLE->SQUARE on the edge where in_valid && in_ready.
REQ-016 SHALL, in SQUARE (1 cycle), form S = vx^2 + vy^2 as 64-bit unsigned; S <= 2^63, so no overflow.
REQ-017 SHALL, in SQRT (32 cycles, 1 result bit per cycle, MSB first), compute R = floor(sqrt(S)), unsigned 32-bit Q16.16.
REQ-018 SHALL, in DIV_X then DIV_Y (17 cycles each, restoring division, quotient bits 16..0), compute Q = floor(|v|*2^16 / R).
REQ-019 SHALL clamp each quotient to 0x0001_0000, then negate it when the source component is negative (two's complement).
REQ-020 SHALL drive mag = min(R, 0x7FFF_FFFF); division always uses the unsaturated R.
REQ-021 SHALL, when R <= ZERO_THRESH, set zero=1 and xn=yn=0, and still run the full state sequence (fixed latency).
REQ-022 SHALL raise out_valid exactly 67 rising edges after the accept edge, independent of data.
REQ-023 SHALL hold mag/xn/yn/zero stable while out_valid=1 && out_ready=0.
REQ-024 SHALL go DONE->IDLE on the edge where out_valid && out_ready; in_ready=1 the following cycle; no accept in the same edge.
REQ-025 SHALL ignore in_valid while not in IDLE; vx/vy changes after accept have no effect.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-computation, immediately enter IDLE and abort without producing a result.
REQ-027 SHALL reset outputs to in_ready=1, out_valid=0, mag=0, xn=0, yn=0, zero=0, and clear all datapath registers.

Configuration
REQ-028 SHALL, with NORMALIZER_ROUND_EN defined, round to nearest:
- R increments by 1 when the final sqrt remainder > R.
- Each quotient increments by 1 when 2*remainder >= R.
- Clamps and latency are unchanged.
REQ-029 SHALL, without NORMALIZER_ROUND_EN, truncate R and both quotients (floor).

Verification
REQ-030 SHALL check vx=0x0003_0000, vy=0x0004_0000 -> mag=0x0005_0000; xn=0x9999, yn=0xCCCC (ROUND_EN: 0x999A, 0xCCCD); out_valid at edge 67.
REQ-031 SHALL check vx=0xFFFD_0000 (-3.0), vy=0x0004_0000 -> xn=0xFFFF_6667, yn=0xCCCC, mag=0x0005_0000.
REQ-032 SHALL check vx=0, vy=0x0014_0000 -> mag=0x0014_0000, xn=0, yn=0x0001_0000 (clamp path); vx=vy=0 -> zero=1, mag=xn=yn=0, same latency.
REQ-033 SHALL check vx=vy=0x8000_0000 -> mag=0x7FFF_FFFF (saturated), xn=yn=0xFFFF_4AFC (truncate mode).
REQ-034 SHALL check out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle; back-to-back vectors then accepted.
REQ-035 SHALL check rst pulsed at cycle 20 of a computation -> out_valid never rises for that vector; in_ready=1; the next vector computes correctly.
